// File: rtl/obi_wrr_arbiter_if.sv
// ---------------------------------------------------------------------------
// obi_wrr_arbiter_if
// Bundles the requester-side and manager-side OBI handshake signals of the
// weighted round-robin arbiter. Only handshakes and selects are carried here;
// the A/R payload is steered outside via sel_o / rsp_sel_o.
//
// Signals (direction as seen from the arbiter):
//   req_i        in   NumReq               per-requester OBI req
//   gnt_o        out  NumReq               per-requester OBI gnt
//   weights_i    in   NumReq*WeightWidth   per-requester weight (0 acts as 1)
//   mgr_req_o    out  1                    manager-port req
//   mgr_gnt_i    in   1                    manager-port gnt
//   sel_o        out  IdxWidth             A-channel select
//   mgr_rvalid_i in   1                    manager-port rvalid
//   mgr_rready_o out  1                    manager-port rready
//   rvalid_o     out  NumReq               per-requester rvalid
//   rready_i     in   NumReq               per-requester rready
//   rsp_sel_o    out  IdxWidth             R-channel select
//   err_o        out  1                    sticky orphan-response flag
// Modports: slave = arbiter view, master = environment/driver view.
// ---------------------------------------------------------------------------
interface obi_wrr_arbiter_if #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned WeightWidth = 4
);
  localparam int unsigned IdxWidth = (NumReq > 32'd1) ? $clog2(NumReq) : 32'd1;

  logic [NumReq-1:0]             req_i;
  logic [NumReq-1:0]             gnt_o;
  logic [NumReq*WeightWidth-1:0] weights_i;
  logic                          mgr_req_o;
  logic                          mgr_gnt_i;
  logic [IdxWidth-1:0]           sel_o;
  logic                          mgr_rvalid_i;
  logic                          mgr_rready_o;
  logic [NumReq-1:0]             rvalid_o;
  logic [NumReq-1:0]             rready_i;
  logic [IdxWidth-1:0]           rsp_sel_o;
  logic                          err_o;

  modport slave (
    input  req_i, weights_i, mgr_gnt_i, mgr_rvalid_i, rready_i,
    output gnt_o, mgr_req_o, sel_o, mgr_rready_o, rvalid_o, rsp_sel_o, err_o
  );

  modport master (
    output req_i, weights_i, mgr_gnt_i, mgr_rvalid_i, rready_i,
    input  gnt_o, mgr_req_o, sel_o, mgr_rready_o, rvalid_o, rsp_sel_o, err_o
  );
endinterface

// File: rtl/obi_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// obi_wrr_arbiter
// Weighted round-robin scheduler sharing one OBI manager port among NumReq
// requesters. Each owner may take up to weight grants per turn (weight 0 acts
// as 1). A pending ungranted request locks the selection so the OBI stability
// rule holds. An in-order FIFO of requester indices routes R-channel valids
// back to the issuing requester.
//
// Ports:
//   clk_i  in  clock, rising edge
//   rst_i  in  asynchronous reset, active-high
//   bus    obi_wrr_arbiter_if.slave (see interface file for the signal list)
//
// Build option:
//   OBI_WRR_ARB_FULL_BYPASS_EN - when defined, a full FIFO still lets
//   mgr_req_o assert in a cycle where a response is popped (push and pop
//   together). When undefined, full always blocks, costing one bubble at
//   saturation but keeping rvalid/rready off the combinational req path.
// ---------------------------------------------------------------------------
module obi_wrr_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned NumMaxTrans = 4,
  parameter int unsigned WeightWidth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  obi_wrr_arbiter_if.slave bus
);

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  localparam int unsigned IdxWidth = idx_width(NumReq);
  localparam int unsigned PtrWidth = idx_width(NumMaxTrans);
  localparam int unsigned CntWidth = idx_width(NumMaxTrans + 32'd1);

  // Arbitration state
  logic [IdxWidth-1:0]    ptr_r;
  logic [WeightWidth-1:0] credit_r;
  logic                   lock_r;
  logic [IdxWidth-1:0]    sel_q_r;

  // Outstanding-transaction FIFO
  logic [IdxWidth-1:0]    fifo_mem_r [NumMaxTrans];
  logic [PtrWidth-1:0]    wr_ptr_r;
  logic [PtrWidth-1:0]    rd_ptr_r;
  logic [CntWidth-1:0]    count_r;
  logic                   err_r;

  // Combinational helpers
  logic [WeightWidth-1:0] weight_s [NumReq];
  logic [IdxWidth-1:0]    cand_s;
  logic [IdxWidth-1:0]    scan_idx_s;
  logic                   scan_hit_s;
  logic                   found_s;
  logic [WeightWidth-1:0] reload_s;
  logic                   empty_s;
  logic                   full_s;
  logic [IdxWidth-1:0]    head_s;
  logic                   mgr_req_s;
  logic                   mgr_rready_s;
  logic                   push_s;
  logic                   pop_s;
  logic [NumReq-1:0]      gnt_s;
  logic [NumReq-1:0]      rvalid_s;

  for (genvar g = 0; g < NumReq; g++) begin : g_weight
    assign weight_s[g] = bus.weights_i[g*WeightWidth +: WeightWidth];
  end

  // Candidate selection: locked index, else current owner with credit left, else next requester after ptr
  always_comb begin
    cand_s     = ptr_r;
    scan_idx_s = ptr_r;
    scan_hit_s = 1'b0;
    found_s    = 1'b0;
    if (lock_r) begin
      cand_s = sel_q_r;
    end else if (bus.req_i[ptr_r] && (credit_r != '0)) begin
      cand_s = ptr_r;
    end else begin
      // ptr itself is visited last (k == NumReq wraps back to ptr)
      for (int unsigned k = 1; k <= NumReq; k++) begin
        scan_idx_s = IdxWidth'((32'(ptr_r) + k) % NumReq);
        scan_hit_s = bus.req_i[scan_idx_s] && !found_s;
        cand_s     = scan_hit_s ? scan_idx_s : cand_s;
        found_s    = found_s | scan_hit_s;
      end
    end
  end

  // Handshake, FIFO status and R-channel routing
  always_comb begin
    reload_s     = (weight_s[cand_s] == '0) ? '0 : (weight_s[cand_s] - WeightWidth'(1));
    empty_s      = (count_r == '0);
    full_s       = (count_r == CntWidth'(NumMaxTrans));
    head_s       = fifo_mem_r[rd_ptr_r];
    // An empty FIFO still accepts (and drops) stray responses
    mgr_rready_s = !rst_i && (empty_s || bus.rready_i[head_s]);
    pop_s        = bus.mgr_rvalid_i && mgr_rready_s && !empty_s;
`ifdef OBI_WRR_ARB_FULL_BYPASS_EN
    mgr_req_s    = !rst_i && (|bus.req_i) && (!full_s || pop_s);
`else
    mgr_req_s    = !rst_i && (|bus.req_i) && !full_s;
`endif
    push_s       = mgr_req_s && bus.mgr_gnt_i;
    gnt_s        = '0;
    if (push_s) begin
      gnt_s[cand_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
    rvalid_s = '0;
    if (bus.mgr_rvalid_i && !empty_s && !rst_i) begin
      rvalid_s[head_s] = 1'b1;
    end else begin
      rvalid_s = '0;
    end
  end

  assign bus.gnt_o        = gnt_s;
  assign bus.mgr_req_o    = mgr_req_s;
  assign bus.sel_o        = rst_i ? '0 : cand_s;
  assign bus.mgr_rready_o = mgr_rready_s;
  assign bus.rvalid_o     = rvalid_s;
  assign bus.rsp_sel_o    = rst_i ? '0 : head_s;
  assign bus.err_o        = err_r;

  // Owner pointer, remaining credit and OBI selection lock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r    <= '0;
      credit_r <= '0;
      lock_r   <= 1'b0;
      sel_q_r  <= '0;
    end else if (push_s) begin
      lock_r <= 1'b0;
      if ((cand_s == ptr_r) && (credit_r != '0)) begin
        credit_r <= credit_r - WeightWidth'(1);
      end else begin
        ptr_r    <= cand_s;
        credit_r <= reload_s;
      end
    end else if (mgr_req_s) begin
      // Request pending without grant: freeze the selection
      lock_r  <= 1'b1;
      sel_q_r <= cand_s;
    end else begin
      lock_r <= lock_r;
    end
  end

  // Outstanding FIFO storage and pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumMaxTrans; i++) begin
        fifo_mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= cand_s;
        wr_ptr_r <= (wr_ptr_r == PtrWidth'(NumMaxTrans - 32'd1)) ? '0 : (wr_ptr_r + PtrWidth'(1));
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PtrWidth'(NumMaxTrans - 32'd1)) ? '0 : (rd_ptr_r + PtrWidth'(1));
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CntWidth'(1);
        2'b01:   count_r <= count_r - CntWidth'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error: a response arrived with nothing outstanding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (bus.mgr_rvalid_i && empty_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_obi_wrr_arbiter.sv
module tb_obi_wrr_arbiter;
  localparam int unsigned NumReq      = 4;
  localparam int unsigned NumMaxTrans = 4;
  localparam int unsigned WeightWidth = 4;
  localparam logic [15:0] WDef = {4'd1, 4'd2, 4'd1, 4'd3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  obi_wrr_arbiter_if #(.NumReq(NumReq), .WeightWidth(WeightWidth)) bus ();

  obi_wrr_arbiter #(
    .NumReq(NumReq), .NumMaxTrans(NumMaxTrans), .WeightWidth(WeightWidth)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [3:0] exp_gnt_q[$];
  logic [3:0] exp_r_q[$];
  int wrr_seq[14] = '{1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3, 0, 0, 0};

  function automatic logic [3:0] onehot(input int idx);
    return 4'b0001 << idx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs_zero(input string tag);
    #1;
    check({tag, "_gnt"}, 32'(bus.gnt_o), 32'd0);
    check({tag, "_mgr_req"}, 32'(bus.mgr_req_o), 32'd0);
    check({tag, "_sel"}, 32'(bus.sel_o), 32'd0);
    check({tag, "_mgr_rready"}, 32'(bus.mgr_rready_o), 32'd0);
    check({tag, "_rvalid"}, 32'(bus.rvalid_o), 32'd0);
    check({tag, "_rsp_sel"}, 32'(bus.rsp_sel_o), 32'd0);
    check({tag, "_err"}, 32'(bus.err_o), 32'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.req_i = 4'b0000; bus.mgr_gnt_i = 1'b0; bus.mgr_rvalid_i = 1'b0;
    bus.rready_i = 4'b1111; bus.weights_i = WDef;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Monitor: pop expected values whenever the DUT shows a grant or an R handshake
  initial begin
    forever begin
      @(negedge clk);
      if (bus.gnt_o != 4'b0000) begin
        if (exp_gnt_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL gnt_unexpected: got %b expected none at %0t", bus.gnt_o, $time);
        end else begin
          check("gnt", 32'(bus.gnt_o), 32'(exp_gnt_q.pop_front()));
        end
      end
      if ((bus.rvalid_o & bus.rready_i) != 4'b0000) begin
        if (exp_r_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rvalid_unexpected: got %b expected none at %0t", bus.rvalid_o, $time);
        end else begin
          check("rvalid", 32'(bus.rvalid_o), 32'(exp_r_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bus.req_i = 4'b0000; bus.weights_i = WDef; bus.mgr_gnt_i = 1'b0;
    bus.mgr_rvalid_i = 1'b0; bus.rready_i = 4'b1111;

    // Reset: outputs held low even with busy inputs
    cyc();
    bus.req_i = 4'b1111; bus.mgr_gnt_i = 1'b1; bus.mgr_rvalid_i = 1'b1;
    check_outs_zero("rst_init");
    cyc();
    rst = 1'b0; bus.mgr_rvalid_i = 1'b0; bus.req_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      exp_gnt_q.push_back(4'b0001);
    end
    // Reset with three outstanding
    cyc();
    bus.req_i = 4'b0000; rst = 1'b1;
    check_outs_zero("rst_mid");
    cyc();
    rst = 1'b0; bus.mgr_rvalid_i = 1'b1;
    #2;
    check("orphan_rvalid_o", 32'(bus.rvalid_o), 32'd0);
    check("orphan_rready", 32'(bus.mgr_rready_o), 32'd1);
    cyc();
    bus.mgr_rvalid_i = 1'b0;
    #2 check("orphan_err", 32'(bus.err_o), 32'd1);
    cyc();
    #2 check("orphan_err_sticky", 32'(bus.err_o), 32'd1);

    // WRR shares with weights {3,1,2,1}
    reset_dut();
    bus.mgr_gnt_i = 1'b1; bus.req_i = 4'b1111;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) cyc();
      bus.mgr_rvalid_i = (i > 0);
      exp_gnt_q.push_back(onehot(wrr_seq[i]));
      if (i > 0) exp_r_q.push_back(onehot(wrr_seq[i-1]));
    end
    cyc();
    bus.req_i = 4'b0000; bus.mgr_rvalid_i = 1'b1;
    exp_r_q.push_back(onehot(wrr_seq[13]));
    cyc();
    bus.mgr_rvalid_i = 1'b0; bus.rready_i = 4'b0000;
    #2;
    check("wrr_empty", 32'(bus.mgr_rready_o), 32'd1);
    check("wrr_err", 32'(bus.err_o), 32'd0);

    // Lock: selection frozen while ungranted
    reset_dut();
    bus.req_i = 4'b0011; bus.mgr_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      #2;
      check("lock_sel", 32'(bus.sel_o), 32'd1);
      check("lock_gnt", 32'(bus.gnt_o), 32'd0);
    end
    cyc();
    bus.req_i = 4'b0010;
    #2 check("lock_sel_drop", 32'(bus.sel_o), 32'd1);
    cyc();
    bus.mgr_gnt_i = 1'b1; exp_gnt_q.push_back(4'b0010);
    cyc();
    bus.req_i = 4'b0001; bus.mgr_gnt_i = 1'b0; bus.mgr_rvalid_i = 1'b1;
    exp_r_q.push_back(4'b0010);
    #2 check("lock2_sel", 32'(bus.sel_o), 32'd0);
    cyc();
    bus.req_i = 4'b0101; bus.mgr_rvalid_i = 1'b0;
    #2 check("lock2_hold", 32'(bus.sel_o), 32'd0);
    cyc();
    bus.mgr_gnt_i = 1'b1; exp_gnt_q.push_back(4'b0001);
    #2 check("lock2_grant_sel", 32'(bus.sel_o), 32'd0);
    cyc();
    bus.req_i = 4'b0000; bus.mgr_gnt_i = 1'b0; bus.mgr_rvalid_i = 1'b1;
    exp_r_q.push_back(4'b0001);
    cyc();
    bus.mgr_rvalid_i = 1'b0;

    // Full FIFO blocks new requests
    reset_dut();
    bus.req_i = 4'b0001; bus.mgr_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      exp_gnt_q.push_back(4'b0001);
    end
    cyc();
    #2;
    check("full_mgr_req", 32'(bus.mgr_req_o), 32'd0);
    check("full_gnt", 32'(bus.gnt_o), 32'd0);
    cyc();
    bus.mgr_rvalid_i = 1'b1; exp_r_q.push_back(4'b0001);
`ifdef OBI_WRR_ARB_FULL_BYPASS_EN
    exp_gnt_q.push_back(4'b0001);
    #2 check("full_bypass_req", 32'(bus.mgr_req_o), 32'd1);
`else
    #2 check("full_pop_req", 32'(bus.mgr_req_o), 32'd0);
    cyc();
    bus.mgr_rvalid_i = 1'b0; exp_gnt_q.push_back(4'b0001);
    #2 check("full_next_req", 32'(bus.mgr_req_o), 32'd1);
`endif
    cyc();
    bus.req_i = 4'b0000; bus.mgr_rvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      exp_r_q.push_back(4'b0001);
    end
    cyc();
    bus.mgr_rvalid_i = 1'b0; bus.rready_i = 4'b0000;
    #2;
    check("full_drained", 32'(bus.mgr_rready_o), 32'd1);
    check("full_err", 32'(bus.err_o), 32'd0);

    // R routing: grants 2,0,2 with back-pressure on requester 0
    reset_dut();
    bus.mgr_gnt_i = 1'b1; bus.req_i = 4'b0100; exp_gnt_q.push_back(4'b0100);
    cyc(); bus.req_i = 4'b0001; exp_gnt_q.push_back(4'b0001);
    cyc(); bus.req_i = 4'b0100; exp_gnt_q.push_back(4'b0100);
    cyc();
    bus.req_i = 4'b0000; bus.mgr_gnt_i = 1'b0; bus.mgr_rvalid_i = 1'b1;
    exp_r_q.push_back(4'b0100);
    #2 check("route_sel0", 32'(bus.rsp_sel_o), 32'd2);
    for (int i = 0; i < 2; i++) begin
      cyc();
      bus.rready_i = 4'b1110;
      #2;
      check("route_hold_rvalid", 32'(bus.rvalid_o), 32'h1);
      check("route_hold_rready", 32'(bus.mgr_rready_o), 32'd0);
      check("route_hold_sel", 32'(bus.rsp_sel_o), 32'd0);
    end
    cyc();
    bus.rready_i = 4'b1111; exp_r_q.push_back(4'b0001);
    cyc();
    exp_r_q.push_back(4'b0100);
    #2 check("route_sel2", 32'(bus.rsp_sel_o), 32'd2);
    cyc();
    bus.mgr_rvalid_i = 1'b0; bus.rready_i = 4'b0000;
    #2;
    check("route_empty", 32'(bus.mgr_rready_o), 32'd1);
    check("route_rvalid_idle", 32'(bus.rvalid_o), 32'd0);
    check("route_err", 32'(bus.err_o), 32'd0);

    // Weight 0 with a single requester
    reset_dut();
    bus.weights_i = {4'd1, 4'd2, 4'd0, 4'd3};
    bus.req_i = 4'b0010; bus.mgr_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      bus.mgr_rvalid_i = (i > 0);
      exp_gnt_q.push_back(4'b0010);
      if (i > 0) exp_r_q.push_back(4'b0010);
    end
    cyc();
    bus.req_i = 4'b1111; bus.mgr_gnt_i = 1'b0; bus.mgr_rvalid_i = 1'b1;
    exp_r_q.push_back(4'b0010);
    #2 check("w0_ptr_next", 32'(bus.sel_o), 32'd2);
    cyc();
    bus.req_i = 4'b0000; bus.mgr_rvalid_i = 1'b0;

    cyc(); cyc(); cyc();
    check("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
    check("r_queue_drained", 32'(exp_r_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
